// File: rtl/xillybus_mem_bank.sv
// Seekable DEPTH x DATA_W register bank behind a Xillybus addressed stream pair,
// with power-up clear, wrap/EOF pointer mode, read coherency bypass and a hardware port.
module xillybus_mem_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int WRAP   = 1
) (
  input  logic              bus_clk,
  input  logic              bus_reset_n,
  input  logic              user_w_mem_wren,
  input  logic [DATA_W-1:0] user_w_mem_data,
  output logic              user_w_mem_full,
  input  logic              user_w_mem_open,
  input  logic              user_r_mem_rden,
  output logic [DATA_W-1:0] user_r_mem_data,
  output logic              user_r_mem_empty,
  output logic              user_r_mem_eof,
  input  logic              user_r_mem_open,
  input  logic [ADDR_W-1:0] user_mem_addr,
  input  logic              user_mem_addr_update,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic              hw_wren,
  input  logic [DATA_W-1:0] hw_wdata,
  output logic [DATA_W-1:0] hw_rdata,
  output logic              hw_collision
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam bit                EOF_MODE = (WRAP == 0);

  typedef enum logic [1:0] {S_CLEAR, S_FETCH, S_VALID, S_END} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr, wr_ptr, rd_ptr, rd_ptr_next, present_addr;
  logic              wr_end, stream_we, read_acc, load_data;
  logic [DATA_W-1:0] data_next;

  assign user_w_mem_full  = (state == S_CLEAR) | (EOF_MODE & wr_end);
  assign user_r_mem_empty = (state != S_VALID);
  assign user_r_mem_eof   = (state == S_END);

  assign stream_we = user_w_mem_wren & user_w_mem_open & ~user_w_mem_full;
  assign read_acc  = user_r_mem_rden & user_r_mem_open & (state == S_VALID)
                   & ~user_mem_addr_update;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_next   = state;
    rd_ptr_next  = rd_ptr;
    present_addr = rd_ptr;
    load_data    = 1'b0;
    case (state)
      S_CLEAR: if (clr_ptr == LAST) state_next = S_FETCH;
      S_FETCH: begin
        if (!user_mem_addr_update) begin
          load_data  = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (user_mem_addr_update) begin
          state_next = S_FETCH;
        end else begin
          load_data = 1'b1;
          if (read_acc) begin
            if (EOF_MODE && rd_ptr == LAST) begin
              state_next = S_END;
              load_data  = 1'b0;
            end else begin
              rd_ptr_next  = rd_ptr + ADDR_W'(1);
              present_addr = rd_ptr_next;
            end
          end
        end
      end
      S_END: if (user_mem_addr_update) state_next = S_FETCH;
      default: state_next = S_CLEAR;
    endcase

    // Same-cycle writes to the word about to be presented bypass the array;
    // the stream write is applied last so it wins over the hardware write.
    data_next = mem[present_addr];
    if (hw_wren && hw_addr == present_addr) data_next = hw_wdata;
    if (stream_we && wr_ptr == present_addr) data_next = user_w_mem_data;
  end

  // NOTE: the array itself has no reset; the CLEAR sequence zeroes it after every reset.
  // Later assignments win, giving CLEAR > stream > hardware priority on a shared address.
  always_ff @(posedge bus_clk) begin
    if (bus_reset_n) begin
      if (hw_wren)            mem[hw_addr] <= hw_wdata;
      if (stream_we)          mem[wr_ptr]  <= user_w_mem_data;
      if (state == S_CLEAR)   mem[clr_ptr] <= '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge bus_clk) begin
    if (!bus_reset_n) begin
      state           <= S_CLEAR;
      clr_ptr         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_end          <= 1'b0;
      user_r_mem_data <= '0;
      hw_rdata        <= '0;
      hw_collision    <= 1'b0;
    end else begin
      state        <= state_next;
      hw_rdata     <= mem[hw_addr];
      hw_collision <= hw_wren & stream_we & (hw_addr == wr_ptr);
      if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
      if (load_data) user_r_mem_data <= data_next;
      // A seek overrides both pointer advances; the write data still lands at the old wr_ptr.
      if (user_mem_addr_update) begin
        wr_ptr <= user_mem_addr;
        rd_ptr <= user_mem_addr;
        wr_end <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr_next;
        if (stream_we) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (EOF_MODE && wr_ptr == LAST) wr_end <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xillybus_mem_bank.sv
// Self-checking bench: drives a WRAP=1 and a WRAP=0 bank with the same stimulus and
// compares both against a behavioural model every cycle, plus literal spot checks.
module tb_xillybus_mem_bank;

  logic       clk = 1'b0;
  logic       rst_n, wren, w_open, rden, r_open, addr_update, hw_wren;
  logic [7:0] w_data, hw_wdata;
  logic [4:0] addr, hw_addr;

  logic [7:0] d_data [2];
  logic [7:0] d_hw   [2];
  logic       d_full [2];
  logic       d_empty[2];
  logic       d_eof  [2];
  logic       d_coll [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xillybus_mem_bank #(.DATA_W(8), .ADDR_W(5), .WRAP(1)) u_wrap (
    .bus_clk(clk), .bus_reset_n(rst_n),
    .user_w_mem_wren(wren), .user_w_mem_data(w_data), .user_w_mem_full(d_full[0]),
    .user_w_mem_open(w_open), .user_r_mem_rden(rden), .user_r_mem_data(d_data[0]),
    .user_r_mem_empty(d_empty[0]), .user_r_mem_eof(d_eof[0]), .user_r_mem_open(r_open),
    .user_mem_addr(addr), .user_mem_addr_update(addr_update),
    .hw_addr(hw_addr), .hw_wren(hw_wren), .hw_wdata(hw_wdata),
    .hw_rdata(d_hw[0]), .hw_collision(d_coll[0])
  );

  xillybus_mem_bank #(.DATA_W(8), .ADDR_W(5), .WRAP(0)) u_eof (
    .bus_clk(clk), .bus_reset_n(rst_n),
    .user_w_mem_wren(wren), .user_w_mem_data(w_data), .user_w_mem_full(d_full[1]),
    .user_w_mem_open(w_open), .user_r_mem_rden(rden), .user_r_mem_data(d_data[1]),
    .user_r_mem_empty(d_empty[1]), .user_r_mem_eof(d_eof[1]), .user_r_mem_open(r_open),
    .user_mem_addr(addr), .user_mem_addr_update(addr_update),
    .hw_addr(hw_addr), .hw_wren(hw_wren), .hw_wdata(hw_wdata),
    .hw_rdata(d_hw[1]), .hw_collision(d_coll[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, index 0 = wrapping bank, 1 = end-of-file bank.
  logic [7:0] m_mem   [2][32];
  bit         m_known [2][32];
  int         clr_left[2], rd[2], wr[2];
  bit         wrend[2], fetch[2], ended[2];
  logic [7:0] e_data[2], e_hw[2];
  bit         e_hw_known[2], e_coll[2];
  bit         model_ready = 1'b0;

  task automatic m_write(input int k, input int a, input logic [7:0] v);
    m_mem[k][a]   = v;
    m_known[k][a] = 1'b1;
  endtask

  task automatic model_step(input int k);
    bit wrap, full_now, valid_now, sw, rd_acc;
    wrap = (k == 0);
    if (!rst_n) begin
      clr_left[k] = 32; rd[k] = 0; wr[k] = 0;
      wrend[k] = 0; fetch[k] = 0; ended[k] = 0;
      e_data[k] = 8'h00; e_hw[k] = 8'h00; e_hw_known[k] = 1; e_coll[k] = 0;
      model_ready = 1'b1;
    end else begin
      full_now  = (clr_left[k] > 0) || (!wrap && wrend[k]);
      valid_now = (clr_left[k] == 0) && !fetch[k] && !ended[k];
      sw        = wren && w_open && !full_now;
      rd_acc    = rden && r_open && valid_now && !addr_update;
      e_hw[k]       = m_mem[k][hw_addr];
      e_hw_known[k] = m_known[k][hw_addr];
      e_coll[k]     = hw_wren && sw && (int'(hw_addr) == wr[k]);
      // Writes are applied first so the presented word naturally reflects same-cycle writes.
      if (hw_wren) m_write(k, int'(hw_addr), hw_wdata);
      if (sw) m_write(k, wr[k], w_data);
      if (clr_left[k] > 0) m_write(k, 32 - clr_left[k], 8'h00);
      if (clr_left[k] > 0) begin
        clr_left[k]--;
        if (clr_left[k] == 0) fetch[k] = 1;
        if (addr_update) begin rd[k] = int'(addr); wr[k] = int'(addr); wrend[k] = 0; end
      end else if (addr_update) begin
        rd[k] = int'(addr); wr[k] = int'(addr); wrend[k] = 0;
        fetch[k] = 1; ended[k] = 0;
      end else begin
        if (sw) begin
          if (!wrap && wr[k] == 31) wrend[k] = 1;
          wr[k] = (wr[k] + 1) % 32;
        end
        if (fetch[k]) begin
          e_data[k] = m_mem[k][rd[k]];
          fetch[k]  = 0;
        end else if (rd_acc) begin
          if (!wrap && rd[k] == 31) ended[k] = 1;
          else begin
            rd[k]     = (rd[k] + 1) % 32;
            e_data[k] = m_mem[k][rd[k]];
          end
        end else if (valid_now) begin
          e_data[k] = m_mem[k][rd[k]];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (model_ready) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model[%0d].data", k), d_data[k], e_data[k]);
        check($sformatf("model[%0d].empty", k), d_empty[k],
              !((clr_left[k] == 0) && !fetch[k] && !ended[k]));
        check($sformatf("model[%0d].eof", k), d_eof[k], ended[k]);
        check($sformatf("model[%0d].full", k), d_full[k],
              (clr_left[k] > 0) || ((k == 1) && wrend[k]));
        check($sformatf("model[%0d].coll", k), d_coll[k], e_coll[k]);
        if (e_hw_known[k]) check($sformatf("model[%0d].hw_rdata", k), d_hw[k], e_hw[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic seek(input logic [4:0] a);
    addr_update = 1'b1; addr = a;
    @(negedge clk);
    addr_update = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, ".data"},  d_data[k],  8'h00);
      check({tag, ".empty"}, d_empty[k], 1'b1);
      check({tag, ".eof"},   d_eof[k],   1'b0);
      check({tag, ".full"},  d_full[k],  1'b1);
      check({tag, ".hw"},    d_hw[k],    8'h00);
      check({tag, ".coll"},  d_coll[k],  1'b0);
    end
  endtask

  initial begin
    rst_n = 0; wren = 0; w_open = 1; rden = 0; r_open = 1; addr_update = 0;
    hw_wren = 0; w_data = 0; hw_wdata = 0; addr = 0; hw_addr = 0;
    cyc(2);
    check_reset_outputs("reset");

    // Power-up clear: 32 clear edges, then one fetch edge presenting mem[0]=0.
    rst_n = 1;
    cyc(31);
    check("clear.full", d_full[0], 1'b1);
    check("clear.empty", d_empty[0], 1'b1);
    cyc(1);
    check("clear_done.full", d_full[0], 1'b0);
    check("clear_done.empty", d_empty[0], 1'b1);
    cyc(1);
    check("first.empty", d_empty[0], 1'b0);
    check("first.data", d_data[0], 8'h00);

    hw_wren = 1; hw_addr = 0; hw_wdata = 8'h10; cyc(1);
    hw_addr = 1; hw_wdata = 8'h11; cyc(1);
    hw_wren = 0;

    // Seek, write three words, seek back and read them.
    seek(3);
    wren = 1; w_data = 8'hA1; cyc(1);
    w_data = 8'hA2; cyc(1);
    w_data = 8'hA3; cyc(1);
    wren = 0;
    seek(3);
    check("seek.empty", d_empty[0], 1'b1);
    cyc(1);
    check("rd0.data", d_data[0], 8'hA1);
    check("rd0.empty", d_empty[0], 1'b0);
    rden = 1; cyc(1);
    check("rd1.data", d_data[0], 8'hA2);
    hw_addr = 4; cyc(1);
    check("rd2.data", d_data[0], 8'hA3);
    cyc(1);
    rden = 0;
    check("rd3.data", d_data[0], 8'h00);
    check("hw4.rdata", d_hw[0], 8'hA2);

    // End of file on the WRAP=0 bank; wrap-around on the WRAP=1 bank.
    seek(30); cyc(1);
    rden = 1; cyc(2); rden = 0;
    check("eof.empty", d_empty[1], 1'b1);
    check("eof.eof", d_eof[1], 1'b1);
    check("wrap30.data", d_data[0], 8'h10);
    check("wrap30.empty", d_empty[0], 1'b0);
    seek(31);
    wren = 1; w_data = 8'h77; cyc(1); wren = 0;
    check("eof_wr31.full", d_full[1], 1'b1);
    check("wrap_wr31.full", d_full[0], 1'b0);
    seek(0);
    check("eof_seek0.full", d_full[1], 1'b0);
    check("eof_seek0.eof", d_eof[1], 1'b0);
    cyc(1);
    check("eof_seek0.empty", d_empty[1], 1'b0);
    check("eof_seek0.data", d_data[1], 8'h10);

    seek(31); cyc(1);
    check("wrap31.data", d_data[0], 8'h77);
    rden = 1; cyc(1);
    check("wrap0.data", d_data[0], 8'h10);
    check("wrap0.empty", d_empty[0], 1'b0);
    cyc(1);
    check("wrap1.data", d_data[0], 8'h11);
    check("wrap1.empty", d_empty[0], 1'b0);
    cyc(1); rden = 0;
    check("wrap2.data", d_data[0], 8'h00);

    // Coherency and hardware-port collision.
    seek(7);
    wren = 1; w_data = 8'h57; cyc(1); wren = 0;
    check("coh7.data", d_data[0], 8'h57);
    rden = 1; wren = 1; w_data = 8'h5C;
    hw_wren = 1; hw_addr = 8; hw_wdata = 8'hEE;
    cyc(1);
    rden = 0; wren = 0; hw_wren = 0;
    check("coh8.data", d_data[0], 8'h5C);
    check("coll.pulse", d_coll[0], 1'b1);
    cyc(1);
    check("coll.drop", d_coll[0], 1'b0);
    check("coll.mem8", d_hw[0], 8'h5C);
    hw_wren = 1; hw_wdata = 8'h99; cyc(1); hw_wren = 0;
    check("hwfwd.data", d_data[0], 8'h99);

    // Reset in the middle of a read burst.
    seek(3); cyc(1);
    rden = 1; cyc(2);
    rst_n = 0; cyc(1);
    check_reset_outputs("midreset");
    rst_n = 1; rden = 0;
    cyc(33);
    check("restart.empty", d_empty[0], 1'b0);
    seek(3); cyc(1);
    check("restart.data3", d_data[0], 8'h00);
    hw_addr = 4; cyc(1);
    check("restart.hw4", d_hw[0], 8'h00);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
